// File: rtl/simd_proc_n_if.sv
// simd_proc_n_if: command descriptor and shared-memory port bundle.
// master = issuer/arbiter side, slave = processing element side.
interface simd_proc_n_if #(
    parameter int LANES  = 5,
    parameter int USIZE  = 16,
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
);
    localparam int BUS_W = LANES * USIZE;
    localparam int SZ_W  = $clog2(LANES + 1);

    logic              i_cmd_valid;
    logic              o_cmd_ready;
    logic [1:0]        i_cmd_op;
    logic [ADDR_W-1:0] i_cmd_src_a;
    logic [ADDR_W-1:0] i_cmd_src_b;
    logic [ADDR_W-1:0] i_cmd_dst;
    logic [CNT_W-1:0]  i_cmd_count;

    logic [ADDR_W-1:0] o_addr;
    logic              o_req_rd;
    logic              i_grant_rd;
    logic [BUS_W-1:0]  i_data;
    logic              o_req_wr;
    logic              i_grant_wr;
    logic              o_wr_en;
    logic [SZ_W-1:0]   o_wr_size;
    logic [BUS_W-1:0]  o_data;

    logic              o_busy;
    logic              o_finish;
    logic              i_ack;

    modport master (
        output i_cmd_valid, i_cmd_op, i_cmd_src_a, i_cmd_src_b,
        output i_cmd_dst, i_cmd_count,
        output i_grant_rd, i_data, i_grant_wr, i_ack,
        input  o_cmd_ready, o_addr, o_req_rd, o_req_wr, o_wr_en,
        input  o_wr_size, o_data, o_busy, o_finish
    );

    modport slave (
        input  i_cmd_valid, i_cmd_op, i_cmd_src_a, i_cmd_src_b,
        input  i_cmd_dst, i_cmd_count,
        input  i_grant_rd, i_data, i_grant_wr, i_ack,
        output o_cmd_ready, o_addr, o_req_rd, o_req_wr, o_wr_en,
        output o_wr_size, o_data, o_busy, o_finish
    );
endinterface

// File: rtl/simd_proc_n.sv
// simd_proc_n: LANES-wide SIMD element streaming A op B from shared memory.
// Define SIMD_PROC_SAT_EN for saturating ADD/SUB/MUL (MAX unaffected).
module simd_proc_n #(
    parameter int LANES  = 5,
    parameter int USIZE  = 16,
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    simd_proc_n_if.slave bus
);
    localparam int BUS_W = LANES * USIZE;
    localparam int SZ_W  = $clog2(LANES + 1);

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_MAX = 2'd3;

    localparam logic [CNT_W-1:0]  LANES_C = CNT_W'(LANES);
    localparam logic [ADDR_W-1:0] LANES_A = ADDR_W'(LANES);
    localparam logic [SZ_W-1:0]   LANES_S = SZ_W'(LANES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH_A,
        S_FETCH_B,
        S_EXEC,
        S_WRITE,
        S_DONE
    } state_t;

    state_t            state_q,   state_d;
    logic [ADDR_W-1:0] addr_a_q,  addr_a_d;
    logic [ADDR_W-1:0] addr_b_q,  addr_b_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [1:0]        op_q,      op_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic [BUS_W-1:0]  reg_a_q,   reg_a_d;
    logic [BUS_W-1:0]  reg_b_q,   reg_b_d;
    logic [BUS_W-1:0]  res_q,     res_d;

    logic [BUS_W-1:0]  alu_res;
    logic [SZ_W-1:0]   wr_size;

    // Exact signed result in double width, then wrap or clamp to USIZE.
    function automatic logic [USIZE-1:0] lane_op(
        input logic [1:0]       op,
        input logic [USIZE-1:0] a,
        input logic [USIZE-1:0] b
    );
        logic signed [2*USIZE-1:0] wa;
        logic signed [2*USIZE-1:0] wb;
        logic signed [2*USIZE-1:0] r;
`ifdef SIMD_PROC_SAT_EN
        logic signed [2*USIZE-1:0] lo;
        logic signed [2*USIZE-1:0] hi;
`endif
        wa = {{USIZE{a[USIZE-1]}}, a};
        wb = {{USIZE{b[USIZE-1]}}, b};
        unique case (op)
            OP_ADD:  r = wa + wb;
            OP_SUB:  r = wa - wb;
            OP_MUL:  r = wa * wb;
            default: r = (wa > wb) ? wa : wb;
        endcase
`ifdef SIMD_PROC_SAT_EN
        lo = {2*USIZE{1'b1}} << (USIZE - 1);
        hi = ~lo;
        if (op != OP_MAX) begin
            if (r > hi) begin
                r = hi;
            end else if (r < lo) begin
                r = lo;
            end
        end
`endif
        return r[USIZE-1:0];
    endfunction

    // Lane-wise ALU on the two fetched operand vectors.
    always_comb begin
        alu_res = '0;
        for (int l = 0; l < LANES; l++) begin
            alu_res[l*USIZE +: USIZE] = lane_op(
                op_q,
                reg_a_q[l*USIZE +: USIZE],
                reg_b_q[l*USIZE +: USIZE]
            );
        end
    end

    // Next-state and datapath register updates.
    always_comb begin
        state_d   = state_q;
        addr_a_d  = addr_a_q;
        addr_b_d  = addr_b_q;
        wr_addr_d = wr_addr_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        reg_a_d   = reg_a_q;
        reg_b_d   = reg_b_q;
        res_d     = res_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.i_cmd_valid) begin
                    addr_a_d  = bus.i_cmd_src_a;
                    addr_b_d  = bus.i_cmd_src_b;
                    wr_addr_d = bus.i_cmd_dst;
                    op_d      = bus.i_cmd_op;
                    cnt_d     = bus.i_cmd_count;
                    if (bus.i_cmd_count == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_FETCH_A;
                    end
                end
            end
            S_FETCH_A: begin
                if (bus.i_grant_rd) begin
                    reg_a_d = bus.i_data;
                    state_d = S_FETCH_B;
                end
            end
            S_FETCH_B: begin
                if (bus.i_grant_rd) begin
                    reg_b_d = bus.i_data;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                res_d   = alu_res;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (bus.i_grant_wr) begin
                    addr_a_d  = addr_a_q + LANES_A;
                    addr_b_d  = addr_b_q + LANES_A;
                    wr_addr_d = wr_addr_q + LANES_A;
                    if (cnt_q <= LANES_C) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = cnt_q - LANES_C;
                        state_d = S_FETCH_A;
                    end
                end
            end
            S_DONE: begin
                if (bus.i_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            addr_a_q  <= '0;
            addr_b_q  <= '0;
            wr_addr_q <= '0;
            op_q      <= '0;
            cnt_q     <= '0;
            reg_a_q   <= '0;
            reg_b_q   <= '0;
            res_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_a_q  <= addr_a_d;
            addr_b_q  <= addr_b_d;
            wr_addr_q <= wr_addr_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            reg_a_q   <= reg_a_d;
            reg_b_q   <= reg_b_d;
            res_q     <= res_d;
        end
    end

    // Write size: remaining count capped at LANES, zero outside WRITE.
    always_comb begin
        wr_size = '0;
        if (state_q == S_WRITE) begin
            if (cnt_q <= LANES_C) begin
                wr_size = SZ_W'(cnt_q);
            end else begin
                wr_size = LANES_S;
            end
        end
    end

    // Port outputs decoded from state; unused write lanes forced to zero.
    always_comb begin
        bus.o_cmd_ready = (state_q == S_IDLE);
        bus.o_busy      = (state_q != S_IDLE);
        bus.o_finish    = (state_q == S_DONE);
        bus.o_req_rd    = (state_q == S_FETCH_A) || (state_q == S_FETCH_B);
        bus.o_req_wr    = (state_q == S_WRITE);
        bus.o_wr_en     = (state_q == S_WRITE) && bus.i_grant_wr;
        bus.o_wr_size   = wr_size;
        bus.o_addr      = wr_addr_q;
        if (state_q == S_FETCH_A) begin
            bus.o_addr = addr_a_q;
        end else if (state_q == S_FETCH_B) begin
            bus.o_addr = addr_b_q;
        end
        bus.o_data = '0;
        for (int l = 0; l < LANES; l++) begin
            if (SZ_W'(l) < wr_size) begin
                bus.o_data[l*USIZE +: USIZE] = res_q[l*USIZE +: USIZE];
            end
        end
    end

endmodule

// File: tb/tb_simd_proc_n.sv
// tb_simd_proc_n: random and directed commands against a memory-level model.
// Expected writes are derived from source memory with plain integer arithmetic.
module tb_simd_proc_n;
    localparam int LANES  = 5;
    localparam int USIZE  = 16;
    localparam int ADDR_W = 16;
    localparam int CNT_W  = 16;
    localparam int BUS_W  = LANES * USIZE;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    simd_proc_n_if #(
        .LANES(LANES), .USIZE(USIZE), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
    ) bus ();

    simd_proc_n #(
        .LANES(LANES), .USIZE(USIZE), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [15:0] mem  [0:65535];
    logic [15:0] wmem [0:65535];

    typedef struct {
        logic [15:0]      addr;
        int               size;
        logic [BUS_W-1:0] data;
    } wr_t;

    wr_t         exp_wr[$];
    logic [15:0] exp_rd[$];

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_op(input int op, input logic [15:0] a,
                                           input logic [15:0] b);
        int sa = $signed(a);
        int sb = $signed(b);
        longint r;
        case (op)
            0:       r = sa + sb;
            1:       r = sa - sb;
            2:       r = sa * sb;
            default: r = (sa > sb) ? sa : sb;
        endcase
`ifdef SIMD_PROC_SAT_EN
        if (op != 3) begin
            if (r > 32767) r = 32767;
            if (r < -32768) r = -32768;
        end
`endif
        return r[15:0];
    endfunction

    function automatic logic [BUS_W-1:0] rd_bus(input logic [15:0] addr);
        logic [BUS_W-1:0] d;
        for (int i = 0; i < LANES; i++) d[i*USIZE +: USIZE] = mem[addr + 16'(i)];
        return d;
    endfunction

    task automatic reset_chk(input string tag);
        chk({tag, "_ready"}, bus.o_cmd_ready, 1);
        chk({tag, "_req_rd"}, bus.o_req_rd, 0);
        chk({tag, "_req_wr"}, bus.o_req_wr, 0);
        chk({tag, "_wr_en"}, bus.o_wr_en, 0);
        chk({tag, "_busy"}, bus.o_busy, 0);
        chk({tag, "_finish"}, bus.o_finish, 0);
        chk({tag, "_wr_size"}, bus.o_wr_size, 0);
        chk({tag, "_data"}, bus.o_data, 0);
        chk({tag, "_addr"}, bus.o_addr, 0);
    endtask

    // Called at posedge+1; returns cycles from acceptance to first DONE cycle.
    task automatic run_cmd(input int op, input logic [15:0] sa,
                           input logic [15:0] sb, input logic [15:0] dst,
                           input int cnt, input int pct, input int fb_stall,
                           input bit spur, output int cyc);
        int chunks = (cnt + LANES - 1) / LANES;
        int stalls = 0;
        int nrd = 0;
        int nwr = 0;
        int fb_left = fb_stall;
        bit done = 0;
        bit pend = 0;
        bit prd = 0;
        bit grd;
        bit gwr;
        logic [15:0] paddr = '0;
        exp_wr.delete();
        exp_rd.delete();
        for (int k = 0; k < chunks; k++) begin
            wr_t w;
            int n = cnt - k * LANES;
            if (n > LANES) n = LANES;
            w.addr = dst + 16'(k * LANES);
            w.size = n;
            w.data = '0;
            for (int i = 0; i < n; i++) begin
                w.data[i*USIZE +: USIZE] = ref_op(op,
                    mem[sa + 16'(k * LANES + i)], mem[sb + 16'(k * LANES + i)]);
            end
            exp_wr.push_back(w);
            exp_rd.push_back(sa + 16'(k * LANES));
            exp_rd.push_back(sb + 16'(k * LANES));
        end
        chk("cmd_ready", bus.o_cmd_ready, 1);
        bus.i_cmd_valid = 1;
        bus.i_cmd_op    = 2'(op);
        bus.i_cmd_src_a = sa;
        bus.i_cmd_src_b = sb;
        bus.i_cmd_dst   = dst;
        bus.i_cmd_count = 16'(cnt);
        @(posedge clk);
        #1;
        cyc = 1;
        chk("busy", bus.o_busy, 1);
        if (spur) begin
            bus.i_cmd_op    = 2'd3;
            bus.i_cmd_src_a = 16'hAAAA;
            bus.i_cmd_src_b = 16'hBBBB;
            bus.i_cmd_dst   = 16'hCCCC;
            bus.i_cmd_count = 16'd1;
        end else begin
            bus.i_cmd_valid = 0;
        end
        while (cyc < 500) begin
            if (bus.o_finish) begin
                done = 1;
                break;
            end
            grd = 0;
            gwr = 0;
            if (pend) begin
                chk("hold_addr", bus.o_addr, paddr);
                chk("hold_req", {bus.o_req_rd, bus.o_req_wr}, {prd, !prd});
            end
            if (bus.o_req_rd) begin
                grd = ($urandom_range(99) >= pct);
                if (nrd == 1 && fb_left > 0) begin
                    grd = 0;
                    fb_left--;
                end
                bus.i_data = rd_bus(bus.o_addr);
            end
            if (bus.o_req_wr) gwr = ($urandom_range(99) >= pct);
            bus.i_grant_rd = grd;
            bus.i_grant_wr = gwr;
            #1;
            chk("wr_en", bus.o_wr_en, gwr);
            if (grd) begin
                nrd++;
                if (exp_rd.size() > 0) chk("rd_addr", bus.o_addr, exp_rd.pop_front());
                else chk("rd_extra", 1, 0);
            end
            if (gwr) begin
                nwr++;
                if (exp_wr.size() > 0) begin
                    wr_t w = exp_wr.pop_front();
                    chk("wr_addr", bus.o_addr, w.addr);
                    chk("wr_size", bus.o_wr_size, w.size);
                    chk("wr_data", bus.o_data, w.data);
                end else begin
                    chk("wr_extra", 1, 0);
                end
                for (int i = 0; i < LANES; i++) begin
                    if (i < int'(bus.o_wr_size))
                        wmem[bus.o_addr + 16'(i)] = bus.o_data[i*USIZE +: USIZE];
                end
            end
            pend  = (bus.o_req_rd && !grd) || (bus.o_req_wr && !gwr);
            if (pend) stalls++;
            prd   = bus.o_req_rd;
            paddr = bus.o_addr;
            @(posedge clk);
            #1;
            bus.i_grant_rd = 0;
            bus.i_grant_wr = 0;
            cyc++;
        end
        chk("finish_seen", done, 1);
        chk("cycles", cyc, 4 * chunks + 1 + stalls);
        chk("n_rd", nrd, 2 * chunks);
        chk("n_wr", nwr, chunks);
        bus.i_cmd_valid = 0;
        for (int h = $urandom_range(2); h > 0; h--) begin
            @(posedge clk);
            #1;
            chk("finish_hold", {bus.o_finish, bus.o_req_rd, bus.o_req_wr}, 3'b100);
        end
        bus.i_ack = 1;
        @(posedge clk);
        #1;
        bus.i_ack = 0;
        chk("ack_idle", {bus.o_cmd_ready, bus.o_finish}, 2'b10);
    endtask

    initial begin
        int cyc;
        logic [15:0] add_exp;
        logic [15:0] sub_exp;
        bus.i_cmd_valid = 0;
        bus.i_cmd_op    = 0;
        bus.i_cmd_src_a = 0;
        bus.i_cmd_src_b = 0;
        bus.i_cmd_dst   = 0;
        bus.i_cmd_count = 0;
        bus.i_grant_rd  = 0;
        bus.i_grant_wr  = 0;
        bus.i_data      = 0;
        bus.i_ack       = 0;
        for (int i = 0; i < 65536; i++) begin
            mem[i]  = 16'($urandom);
            wmem[i] = 16'hDEAD;
        end

        #3;
        reset_chk("rst");
        @(posedge clk);
        #1;
        rst = 0;
        @(posedge clk);
        #1;
        reset_chk("idle");

        for (int i = 0; i < 5; i++) begin
            mem[i]      = 16'(i + 1);
            mem[16 + i] = 16'(10 * (i + 1));
        end
        run_cmd(0, 16'd0, 16'd16, 16'd32, 5, 0, 0, 0, cyc);
        chk("add_fin_cycle", cyc, 5);
        for (int i = 0; i < 5; i++) chk("add_lane", wmem[32 + i], 16'(11 * (i + 1)));

        run_cmd(2, 16'd100, 16'd200, 16'd300, 7, 0, 0, 0, cyc);
        chk("mul_fin_cycle", cyc, 9);
        chk("mul_no_spill", wmem[307], 16'hDEAD);

        run_cmd(0, 16'd1, 16'd2, 16'd3, 0, 0, 0, 0, cyc);
        chk("zero_fin_cycle", cyc, 1);

        run_cmd(1, 16'd400, 16'd500, 16'd600, 5, 0, 3, 1, cyc);
        chk("stall_fin_cycle", cyc, 8);

`ifdef SIMD_PROC_SAT_EN
        add_exp = 16'h7FFF;
        sub_exp = 16'h8000;
`else
        add_exp = 16'h8000;
        sub_exp = 16'h7FFF;
`endif
        mem[700] = 16'h7FFF;
        mem[710] = 16'h0001;
        run_cmd(0, 16'd700, 16'd710, 16'd720, 1, 0, 0, 0, cyc);
        chk("sat_add", wmem[720], add_exp);
        mem[730] = 16'h8000;
        mem[740] = 16'h0001;
        run_cmd(1, 16'd730, 16'd740, 16'd750, 1, 0, 0, 0, cyc);
        chk("sat_sub", wmem[750], sub_exp);

        bus.i_cmd_valid = 1;
        bus.i_cmd_op    = 0;
        bus.i_cmd_src_a = 16'd0;
        bus.i_cmd_src_b = 16'd16;
        bus.i_cmd_dst   = 16'd900;
        bus.i_cmd_count = 16'd5;
        @(posedge clk);
        #1;
        bus.i_cmd_valid = 0;
        for (int i = 0; i < 10 && !bus.o_req_wr; i++) begin
            bus.i_grant_rd = bus.o_req_rd;
            bus.i_data     = rd_bus(bus.o_addr);
            @(posedge clk);
            #1;
        end
        bus.i_grant_rd = 0;
        chk("rw_in_write", bus.o_req_wr, 1);
        bus.i_grant_wr = 1;
        rst = 1;
        #1;
        reset_chk("midrst");
        @(posedge clk);
        #1;
        chk("midrst_wr_en", bus.o_wr_en, 0);
        bus.i_grant_wr = 0;
        rst = 0;
        chk("midrst_no_write", wmem[900], 16'hDEAD);
        @(posedge clk);
        #1;
        run_cmd(3, 16'd0, 16'd16, 16'd910, 6, 0, 0, 0, cyc);

        for (int t = 0; t < 30; t++) begin
            run_cmd($urandom_range(3), 16'($urandom), 16'($urandom),
                    16'($urandom), $urandom_range(23), 30, 0,
                    1'($urandom_range(1)), cyc);
        end
        run_cmd(2, 16'hFFFC, 16'hFFFE, 16'h8000, 12, 20, 0, 0, cyc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/simd_proc_n.md
# simd_proc_n

Parametrised SIMD processing element, the successor to the fixed 5-lane unit. It takes a single-beat command descriptor with two source addresses, a destination address, an element count and an opcode. It then streams operand vectors from shared memory through a LANES-wide ALU and writes results back, repeating until the count is exhausted. It sits between the command issuer/scoreboard and the shared-memory arbiter, alongside other processing elements.

## Interface
Parameters:
- LANES, 5, number of SIMD lanes (≥1)
- USIZE, 16, element width in bits
- ADDR_W, 16, element-address width
- CNT_W, 16, element-count width
- derived: BUS_W = LANES*USIZE; SZ_W = $clog2(LANES+1)

Ports:
- i_clk  in  1  clock; all logic on rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_cmd_valid  in  1  command descriptor valid
- o_cmd_ready  out  1  high only in IDLE
- i_cmd_op  in  2  0 ADD, 1 SUB, 2 MUL, 3 MAX (signed)
- i_cmd_src_a / i_cmd_src_b / i_cmd_dst  in  ADDR_W  start element addresses
- i_cmd_count  in  CNT_W  element count
- o_addr  out  ADDR_W  shared-memory address
- o_req_rd  out  1  read request
- i_grant_rd  in  1  read grant; i_data valid in the same cycle
- i_data  in  BUS_W  read data, lane 0 in LSBs
- o_req_wr  out  1  write request
- i_grant_wr  in  1  write grant; write commits in the same cycle
- o_wr_en  out  1  o_req_wr & i_grant_wr
- o_wr_size  out  SZ_W  valid lanes in the current write
- o_data  out  BUS_W  write data; inactive lanes are zero
- o_busy  out  1  state != IDLE
- o_finish  out  1  high in DONE
- i_ack  in  1  issuer acknowledge of finish

## Operation
- States: IDLE, FETCH_A, FETCH_B, EXEC, WRITE, DONE.
- IDLE: when i_cmd_valid is seen, latch the descriptor into addr_a, addr_b, wr_addr, op and cnt.
  - count == 0 → DONE.
  - otherwise → FETCH_A.
- FETCH_A: o_addr=addr_a, o_req_rd=1. On i_grant_rd, capture i_data into reg_a → FETCH_B.
- FETCH_B: o_addr=addr_b, o_req_rd=1. On i_grant_rd, capture i_data into reg_b → EXEC.
- EXEC: compute lane-wise reg_a op reg_b into a registered result → WRITE. No memory request.
- WRITE: o_addr=wr_addr, o_req_wr=1, o_wr_size=min(cnt, LANES). On i_grant_wr:
  - addr_a, addr_b and wr_addr each advance by LANES, modulo 2^ADDR_W.
  - cnt ≤ LANES → DONE.
  - otherwise cnt -= LANES → FETCH_A.
- DONE: o_finish=1 until i_ack → IDLE.
- Arithmetic is per lane, with signed USIZE operands:
  - ADD/SUB: wrap modulo 2^USIZE.
  - MUL: low USIZE bits of the 2·USIZE signed product.
  - MAX: signed max.
- Lanes ≥ o_wr_size are driven to 0 on o_data.
- o_addr in IDLE/EXEC/DONE equals wr_addr; it is don't-care for the arbiter.
- i_cmd_valid outside IDLE is ignored; no queueing.
- i_ack outside DONE is ignored.
- No request is deasserted while waiting for a grant; addresses and size stay stable until granted.

## Timing
- Reset values:
  - state=IDLE, o_cmd_ready=1.
  - o_req_rd=o_req_wr=o_wr_en=o_busy=o_finish=0.
  - o_wr_size=0, o_data=0, o_addr=0; all internal registers 0.
- Zero-wait grants give 4 cycles per chunk. Command accepted at cycle 0:
  - FETCH_A at 1, FETCH_B at 2, EXEC at 3, WRITE at 4 (o_wr_en=1).
  - Next FETCH_A at 5, or DONE at 5.
- Each wait cycle without a grant adds exactly one cycle.
- Reset asserted mid-operation: immediate return to reset values. Any pending write is dropped and no o_wr_en is produced.
- A cnt that is not a multiple of LANES gives a final write with o_wr_size = cnt mod LANES.

## Configuration
- SIMD_PROC_SAT_EN defined:
  - ADD, SUB and MUL saturate to [-2^(USIZE-1), 2^(USIZE-1)-1].
  - MAX is unchanged.
- SIMD_PROC_SAT_EN undefined: wrapping arithmetic as specified in Operation.

## Test plan
- Reset with LANES=5, USIZE=16 → all outputs at reset values; o_cmd_ready=1. Then an ADD, count=5, src_a=0, src_b=16, dst=32, lanes {1..5}+{10..50}, zero-wait grants:
  - exactly one write at addr 32, o_wr_size=5, o_data lanes {11,22,33,44,55}.
  - o_finish at cycle 5.
  - i_ack → IDLE.
- MUL, count=7 → two writes:
  - first at dst, size 5.
  - second at dst+5, size 2, lanes 2–4 zero; read addresses advance by 5.
- count=0 → DONE the next cycle with no o_req_rd or o_req_wr ever asserted; held until i_ack.
- i_grant_rd withheld 3 cycles in FETCH_B → o_addr=src_b and o_req_rd held stable; WRITE is reached 3 cycles later than zero-wait. A second i_cmd_valid while busy is ignored.
- ADD of 0x7FFF + 0x0001:
  - result 0x8000 without SIMD_PROC_SAT_EN, 0x7FFF with it.
  - SUB 0x8000 − 1 gives 0x7FFF without and 0x8000 with.
- i_rst asserted during WRITE before the grant → no o_wr_en; outputs at reset values the same cycle; a new command after deassertion runs correctly.
